// File: rtl/pacman_pkg.sv
// Shared game-state types and BCD point values for the Pac-Man scoring path.
package pacman_pkg;

    typedef enum logic [2:0] {
        INI     = 3'd0,
        PLAY    = 3'd1,
        RESPAWN = 3'd2,
        WIN     = 3'd3,
        LOSE    = 3'd4
    } game_state_t;

    localparam logic [15:0] PTS_PELLET = 16'h0010;
    localparam logic [15:0] PTS_POWER  = 16'h0050;
    localparam logic [15:0] PTS_GHOST  = 16'h0200;
    localparam logic [15:0] SCORE_MAX  = 16'h9999;

    // No two constants share a non-zero digit position beyond 1+5, so the
    // plain binary sum is already a valid BCD value (max 16'h0260).
    function automatic logic [15:0] event_points(input logic pellet,
                                                 input logic power,
                                                 input logic ghost);
        logic [15:0] pts;
        pts = 16'h0000;
        if (pellet) pts = pts + PTS_PELLET;
        if (power)  pts = pts + PTS_POWER;
        if (ghost)  pts = pts + PTS_GHOST;
        return pts;
    endfunction

endpackage

// File: rtl/bcd_add4.sv
// Combinational 4-digit BCD adder; digit 3 in [15:12], carry out of digit 3 on cout.
module bcd_add4 (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [15:0] sum,
    output logic        cout
);

    logic [4:0] w_dig;
    logic       w_c;

    always_comb begin
        sum   = 16'h0000;
        w_dig = 5'd0;
        w_c   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w_dig = {1'b0, i_a[4*i +: 4]} + {1'b0, i_b[4*i +: 4]} + {4'd0, w_c};
            if (w_dig > 5'd9) begin
                sum[4*i +: 4] = 4'(w_dig + 5'd6);
                w_c           = 1'b1;
            end else begin
                sum[4*i +: 4] = w_dig[3:0];
                w_c           = 1'b0;
            end
        end
        cout = w_c;
    end

endmodule

// File: rtl/score_keeper.sv
// Game-state FSM, BCD score, lives, pellets and respawn freeze timer.
//   state   | meaning
//   INI     | waiting for start, counters held at initial values
//   PLAY    | events update score/pellets/lives
//   RESPAWN | freeze for RESPAWN_CYC cycles after losing a life
//   WIN     | all pellets eaten, frozen until ack
//   LOSE    | no lives left, frozen until ack
module score_keeper
    import pacman_pkg::*;
#(
    parameter int PELLET_TOTAL = 240,
    parameter int LIVES        = 3,
    parameter int RESPAWN_CYC  = 100_000_000
) (
    input  logic        board_clk,
    input  logic        Reset,
    input  logic        start,
    input  logic        ack,
    input  logic        pellet_eaten,
    input  logic        power_eaten,
    input  logic        ghost_eaten,
    input  logic        ghost_hit,
    output logic [15:0] score,
    output logic [1:0]  lives_left,
    output logic [8:0]  pellets_left,
    output logic        playing,
    output logic        respawn,
    output logic        win,
    output logic        lose
);

    localparam int CNT_W = (RESPAWN_CYC > 1) ? $clog2(RESPAWN_CYC) : 1;
    localparam logic [8:0]       PEL_INIT  = 9'(PELLET_TOTAL);
    localparam logic [1:0]       LIV_INIT  = 2'(LIVES);
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(RESPAWN_CYC - 1);

    game_state_t       r_state;
    logic [15:0]       r_score;
    logic [1:0]        r_lives;
    logic [8:0]        r_pellets;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_playing;
    logic              r_respawn;
    logic              r_win;
    logic              r_lose;

    logic [15:0]       w_points;
    logic [15:0]       w_sum;
    logic              w_cout;
    logic [15:0]       w_score_upd;
    logic [1:0]        w_pel_dec;
    logic [8:0]        w_pel_upd;
    logic [1:0]        w_lives_dec;

    assign w_points = event_points(pellet_eaten, power_eaten, ghost_eaten);

    bcd_add4 u_bcd_add4 (
        .i_a  (r_score),
        .i_b  (w_points),
        .sum  (w_sum),
        .cout (w_cout)
    );

    assign w_score_upd = w_cout ? SCORE_MAX : w_sum;
    assign w_pel_dec   = {1'b0, pellet_eaten} + {1'b0, power_eaten};
    assign w_pel_upd   = (r_pellets > {7'd0, w_pel_dec}) ? (r_pellets - {7'd0, w_pel_dec}) : 9'd0;
    assign w_lives_dec = (r_lives != 2'd0) ? (r_lives - 2'd1) : 2'd0;

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= INI;
            r_score   <= 16'h0000;
            r_lives   <= LIV_INIT;
            r_pellets <= PEL_INIT;
            r_cnt     <= '0;
            r_playing <= 1'b0;
            r_respawn <= 1'b0;
            r_win     <= 1'b0;
            r_lose    <= 1'b0;
        end else begin
            case (r_state)
                INI: begin
                    r_score   <= 16'h0000;
                    r_lives   <= LIV_INIT;
                    r_pellets <= PEL_INIT;
                    r_cnt     <= '0;
                    if (start) begin
                        r_state   <= PLAY;
                        r_playing <= 1'b1;
                    end
                end
                PLAY: begin
                    r_score   <= w_score_upd;
                    r_pellets <= w_pel_upd;
                    // Clearing the maze wins even if Pac-Man is caught on the same cycle.
                    if (w_pel_upd == 9'd0) begin
                        r_state   <= WIN;
                        r_playing <= 1'b0;
                        r_win     <= 1'b1;
                    end else if (ghost_hit) begin
                        r_lives   <= w_lives_dec;
                        r_playing <= 1'b0;
                        if (w_lives_dec == 2'd0) begin
                            r_state <= LOSE;
                            r_lose  <= 1'b1;
                        end else begin
                            r_state   <= RESPAWN;
                            r_respawn <= 1'b1;
                            r_cnt     <= CNT_LOAD;
                        end
                    end
                end
                RESPAWN: begin
                    if (r_cnt == '0) begin
                        r_state   <= PLAY;
                        r_respawn <= 1'b0;
                        r_playing <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                WIN, LOSE: begin
                    if (ack) begin
                        r_state   <= INI;
                        r_win     <= 1'b0;
                        r_lose    <= 1'b0;
                        r_score   <= 16'h0000;
                        r_lives   <= LIV_INIT;
                        r_pellets <= PEL_INIT;
                    end
                end
                default: begin
                    r_state   <= INI;
                    r_playing <= 1'b0;
                    r_respawn <= 1'b0;
                    r_win     <= 1'b0;
                    r_lose    <= 1'b0;
                end
            endcase
        end
    end

    assign score        = r_score;
    assign lives_left   = r_lives;
    assign pellets_left = r_pellets;
    assign playing      = r_playing;
    assign respawn      = r_respawn;
    assign win          = r_win;
    assign lose         = r_lose;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: table-driven vectors plus corner sequences, checked through a scoreboard queue.
module tb_score_keeper;

    localparam logic [5:0] E_ST  = 6'b100000;
    localparam logic [5:0] E_ACK = 6'b010000;
    localparam logic [5:0] E_PEL = 6'b001000;
    localparam logic [5:0] E_POW = 6'b000100;
    localparam logic [5:0] E_GE  = 6'b000010;
    localparam logic [5:0] E_GH  = 6'b000001;
    localparam logic [3:0] F_PLAY = 4'b1000;
    localparam logic [3:0] F_RESP = 4'b0100;
    localparam logic [3:0] F_WIN  = 4'b0010;
    localparam logic [3:0] F_LOSE = 4'b0001;

    typedef struct {
        logic [5:0]  ev;
        logic [15:0] sc;
        logic [1:0]  lv;
        logic [8:0]  pl;
        logic [3:0]  fl;
    } vec_t;

    typedef struct {
        string       name;
        bit          sel;
        logic [30:0] val;
    } exp_t;

    logic board_clk, Reset, start, ack, pellet_eaten, power_eaten, ghost_eaten, ghost_hit;
    logic [15:0] a_score, b_score;
    logic [1:0]  a_lives, b_lives;
    logic [8:0]  a_pel, b_pel;
    logic        a_play, a_resp, a_win, a_lose;
    logic        b_play, b_resp, b_win, b_lose;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    vec_t tbl[26];
    int   m_score;
    int   m_pel;

    score_keeper #(.PELLET_TOTAL(240), .LIVES(3), .RESPAWN_CYC(4)) dut_a (
        .board_clk(board_clk), .Reset(Reset), .start(start), .ack(ack),
        .pellet_eaten(pellet_eaten), .power_eaten(power_eaten),
        .ghost_eaten(ghost_eaten), .ghost_hit(ghost_hit),
        .score(a_score), .lives_left(a_lives), .pellets_left(a_pel),
        .playing(a_play), .respawn(a_resp), .win(a_win), .lose(a_lose));

    score_keeper #(.PELLET_TOTAL(2), .LIVES(3), .RESPAWN_CYC(4)) dut_b (
        .board_clk(board_clk), .Reset(Reset), .start(start), .ack(ack),
        .pellet_eaten(pellet_eaten), .power_eaten(power_eaten),
        .ghost_eaten(ghost_eaten), .ghost_hit(ghost_hit),
        .score(b_score), .lives_left(b_lives), .pellets_left(b_pel),
        .playing(b_play), .respawn(b_resp), .win(b_win), .lose(b_lose));

    initial board_clk = 1'b0;
    always #5 board_clk = ~board_clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [30:0] dut_out(input bit sel);
        if (sel) return {b_score, b_lives, b_pel, b_play, b_resp, b_win, b_lose};
        return {a_score, a_lives, a_pel, a_play, a_resp, a_win, a_lose};
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string name, input logic [30:0] act, input logic [30:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got score=%h lives=%0d pellets=%0d flags=%b exp score=%h lives=%0d pellets=%0d flags=%b",
                     name, act[30:15], act[14:13], act[12:4], act[3:0],
                     expv[30:15], expv[14:13], expv[12:4], expv[3:0]);
        end
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: got empty queue exp entry");
        end else begin
            e = sb.pop_front();
            check(e.name, dut_out(e.sel), e.val);
        end
    endtask

    task automatic step(input logic [5:0] ev, input bit sel, input logic [15:0] sc,
                        input logic [1:0] lv, input logic [8:0] pl, input logic [3:0] fl,
                        input string nm);
        exp_t e;
        @(negedge board_clk);
        {start, ack, pellet_eaten, power_eaten, ghost_eaten, ghost_hit} = ev;
        e.name = nm;
        e.sel  = sel;
        e.val  = {sc, lv, pl, fl};
        sb.push_back(e);
        @(posedge board_clk);
        #1;
        {start, ack, pellet_eaten, power_eaten, ghost_eaten, ghost_hit} = 6'b0;
        pop_check();
    endtask

    task automatic do_reset();
        @(negedge board_clk);
        Reset = 1'b1;
        @(negedge board_clk);
        Reset = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        {start, ack, pellet_eaten, power_eaten, ghost_eaten, ghost_hit} = 6'b0;

        tbl[0]  = '{E_ST,          16'h0000, 2'd3, 9'd240, F_PLAY};
        tbl[1]  = '{E_PEL,         16'h0010, 2'd3, 9'd239, F_PLAY};
        tbl[2]  = '{E_PEL,         16'h0020, 2'd3, 9'd238, F_PLAY};
        tbl[3]  = '{E_PEL,         16'h0030, 2'd3, 9'd237, F_PLAY};
        tbl[4]  = '{6'b0,          16'h0030, 2'd3, 9'd237, F_PLAY};
        tbl[5]  = '{E_POW,         16'h0080, 2'd3, 9'd236, F_PLAY};
        tbl[6]  = '{E_PEL,         16'h0090, 2'd3, 9'd235, F_PLAY};
        tbl[7]  = '{E_PEL,         16'h0100, 2'd3, 9'd234, F_PLAY};
        tbl[8]  = '{E_PEL | E_POW, 16'h0160, 2'd3, 9'd232, F_PLAY};
        tbl[9]  = '{E_GE,          16'h0360, 2'd3, 9'd232, F_PLAY};
        tbl[10] = '{E_ST,          16'h0360, 2'd3, 9'd232, F_PLAY};
        tbl[11] = '{E_GH,          16'h0360, 2'd2, 9'd232, F_RESP};
        tbl[12] = '{E_PEL,         16'h0360, 2'd2, 9'd232, F_RESP};
        tbl[13] = '{E_GE,          16'h0360, 2'd2, 9'd232, F_RESP};
        tbl[14] = '{6'b0,          16'h0360, 2'd2, 9'd232, F_RESP};
        tbl[15] = '{6'b0,          16'h0360, 2'd2, 9'd232, F_PLAY};
        tbl[16] = '{E_GH,          16'h0360, 2'd1, 9'd232, F_RESP};
        tbl[17] = '{6'b0,          16'h0360, 2'd1, 9'd232, F_RESP};
        tbl[18] = '{6'b0,          16'h0360, 2'd1, 9'd232, F_RESP};
        tbl[19] = '{6'b0,          16'h0360, 2'd1, 9'd232, F_RESP};
        tbl[20] = '{6'b0,          16'h0360, 2'd1, 9'd232, F_PLAY};
        tbl[21] = '{E_GH,          16'h0360, 2'd0, 9'd232, F_LOSE};
        tbl[22] = '{E_PEL,         16'h0360, 2'd0, 9'd232, F_LOSE};
        tbl[23] = '{E_ST,          16'h0360, 2'd0, 9'd232, F_LOSE};
        tbl[24] = '{E_ACK,         16'h0000, 2'd3, 9'd240, 4'b0000};
        tbl[25] = '{E_ACK,         16'h0000, 2'd3, 9'd240, 4'b0000};

        @(negedge board_clk);
        check("reset_a", dut_out(1'b0), {16'h0000, 2'd3, 9'd240, 4'b0000});
        check("reset_b", dut_out(1'b1), {16'h0000, 2'd3, 9'd2, 4'b0000});
        Reset = 1'b0;

        for (int i = 0; i < 26; i++)
            step(tbl[i].ev, 1'b0, tbl[i].sc, tbl[i].lv, tbl[i].pl, tbl[i].fl, $sformatf("vec%0d", i));

        // Climb to 9800 with ghosts, then overflow with all three point events at once.
        m_score = 0;
        m_pel   = 240;
        step(E_ST, 1'b0, to_bcd(m_score), 2'd3, 9'(m_pel), F_PLAY, "sat_start");
        for (int i = 0; i < 49; i++) begin
            m_score = m_score + 200;
            step(E_GE, 1'b0, to_bcd(m_score), 2'd3, 9'(m_pel), F_PLAY, $sformatf("ghost%0d", i));
        end
        m_score = (m_score + 260 > 9999) ? 9999 : m_score + 260;
        m_pel   = m_pel - 2;
        step(E_PEL | E_POW | E_GE, 1'b0, to_bcd(m_score), 2'd3, 9'(m_pel), F_PLAY, "sat_all3");
        m_pel = m_pel - 1;
        step(E_PEL, 1'b0, to_bcd(m_score), 2'd3, 9'(m_pel), F_PLAY, "sat_hold");

        // Win beats a simultaneous ghost hit on the last life.
        do_reset();
        step(E_ST, 1'b1, 16'h0000, 2'd3, 9'd2, F_PLAY, "w_start");
        step(E_GH, 1'b1, 16'h0000, 2'd2, 9'd2, F_RESP, "w_hit1");
        for (int i = 0; i < 3; i++) step(6'b0, 1'b1, 16'h0000, 2'd2, 9'd2, F_RESP, "w_resp1");
        step(6'b0, 1'b1, 16'h0000, 2'd2, 9'd2, F_PLAY, "w_back1");
        step(E_GH, 1'b1, 16'h0000, 2'd1, 9'd2, F_RESP, "w_hit2");
        for (int i = 0; i < 3; i++) step(6'b0, 1'b1, 16'h0000, 2'd1, 9'd2, F_RESP, "w_resp2");
        step(6'b0, 1'b1, 16'h0000, 2'd1, 9'd2, F_PLAY, "w_back2");
        step(E_PEL, 1'b1, 16'h0010, 2'd1, 9'd1, F_PLAY, "w_pel");
        step(E_PEL | E_GH, 1'b1, 16'h0020, 2'd1, 9'd0, F_WIN, "w_win");
        step(E_GE, 1'b1, 16'h0020, 2'd1, 9'd0, F_WIN, "w_frozen");
        step(E_ST | E_ACK, 1'b1, 16'h0000, 2'd3, 9'd2, 4'b0000, "w_ackstart");
        step(E_ST, 1'b1, 16'h0000, 2'd3, 9'd2, F_PLAY, "w_start2");
        step(E_PEL | E_POW, 1'b1, 16'h0060, 2'd3, 9'd0, F_WIN, "w_floor");

        // Asynchronous reset in the middle of RESPAWN.
        do_reset();
        step(E_ST, 1'b0, 16'h0000, 2'd3, 9'd240, F_PLAY, "r_start");
        step(E_PEL | E_GH, 1'b0, 16'h0010, 2'd2, 9'd239, F_RESP, "r_hit");
        step(6'b0, 1'b0, 16'h0010, 2'd2, 9'd239, F_RESP, "r_resp");
        #2;
        Reset = 1'b1;
        #1;
        check("r_async_a", dut_out(1'b0), {16'h0000, 2'd3, 9'd240, 4'b0000});
        check("r_async_b", dut_out(1'b1), {16'h0000, 2'd3, 9'd2, 4'b0000});
        @(negedge board_clk);
        Reset = 1'b0;
        step(6'b0, 1'b0, 16'h0000, 2'd3, 9'd240, 4'b0000, "r_ini");
        step(E_ST | E_ACK, 1'b0, 16'h0000, 2'd3, 9'd240, F_PLAY, "r_one");
        step(6'b0, 1'b0, 16'h0000, 2'd3, 9'd240, F_PLAY, "r_stay1");
        step(6'b0, 1'b0, 16'h0000, 2'd3, 9'd240, F_PLAY, "r_stay2");

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d left exp 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
